// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: function codes and the
// sequencer state encoding mirrored by the control unit's debug view.
package muldiv_unit_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1a;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StMult   = 3'd1,
    StDiv    = 3'd2,
    StDivFix = 3'd3,
    StDone   = 3'd4,
    StDzero  = 3'd5
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit one quotient bit.
module muldiv_unit_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    fits      = rem_shift >= {1'b0, divisor};
    // When it fits the difference is below the divisor, so WIDTH bits suffice.
    diff      = rem_shift[WIDTH-1:0] - divisor;
    rem_next  = fits ? diff : rem_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring) unit that
// answers the CPU control unit with done / divZero pulses.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             initMult,
  input  logic             initDiv,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  localparam logic [2:0] StateIdle   = StIdle;
  localparam logic [2:0] StateMult   = StMult;
  localparam logic [2:0] StateDiv    = StDiv;
  localparam logic [2:0] StateDivFix = StDivFix;
  localparam logic [2:0] StateDone   = StDone;
  localparam logic [2:0] StateDzero  = StDzero;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   booth_m;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   acc_shift;
  logic [WIDTH-1:0] mq_shift;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Booth step over {acc, mq, q-1}; the extra accumulator bit keeps -2^(W-1)
  // squared exact.
  always_comb begin
    booth_m = {mcand_q[WIDTH-1], mcand_q};
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + booth_m;
      2'b10:   booth_sum = acc_q - booth_m;
      default: booth_sum = acc_q;
    endcase
    acc_shift = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mq_shift  = {booth_sum[0], mq_q[WIDTH-1:1]};
  end

  assign a_mag   = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_mag   = b_in[WIDTH-1] ? -b_in : b_in;
  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  muldiv_unit_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    qm1_d     = qm1_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      StateIdle: begin
        if (initMult) begin
          state_d = StateMult;
          cnt_d   = '0;
          acc_d   = '0;
          mq_d    = b_in;
          qm1_d   = 1'b0;
          mcand_d = a_in;
        end else if (initDiv) begin
          if (b_in != '0) begin
            state_d   = StateDiv;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = a_mag;
            dvsr_d    = b_mag;
            neg_quo_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            neg_rem_d = a_in[WIDTH-1];
          end else begin
            state_d = StateDzero;
          end
        end
      end

      StateMult: begin
        acc_d = acc_shift;
        mq_d  = mq_shift;
        qm1_d = mq_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          hi_d    = acc_shift[WIDTH-1:0];
          lo_d    = mq_shift;
          state_d = StateDone;
        end
      end

      StateDiv: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StateDivFix;
        end
      end

      StateDivFix: begin
        hi_d    = rem_fix;
        lo_d    = quo_fix;
        state_d = StateDone;
      end

      StateDone,
      StateDzero: state_d = StateIdle;

      default: state_d = StateIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StateIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      qm1_q     <= 1'b0;
      mcand_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      qm1_q     <= qm1_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign busy    = (state_q == StateMult) || (state_q == StateDiv) || (state_q == StateDivFix);
  assign done    = (state_q == StateDone);
  assign divZero = (state_q == StateDzero);

endmodule
